// File: rtl/and_or_pipe_pkg.sv
// Shared constants for the and_or_pipe streaming AND/OR datapath.
package and_or_pipe_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 2;
  localparam int DEF_COUNT_W = 16;

  // Selects which AND result feeds the OR of a sample.
  localparam logic ORDER_PREV = 1'b0;
  localparam logic ORDER_CURR = 1'b1;

endpackage

// File: rtl/and_or_pipe_stage.sv
// One valid/ready register slice; a bubble or a moving successor lets it load.
module and_or_pipe_stage #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_up_valid,
  input  logic [DATA_W-1:0] i_up_data,
  output logic              o_up_ready,
  output logic              o_dn_valid,
  output logic [DATA_W-1:0] o_dn_data,
  input  logic              i_dn_ready
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  assign o_up_ready = !r_valid || i_dn_ready;
  assign o_dn_valid = r_valid;
  assign o_dn_data  = r_data;

  // Data only loads with a real sample so the outputs keep their last value on bubbles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_up_ready) begin
      r_valid <= i_up_valid;
      if (i_up_valid) r_data <= i_up_data;
    end
  end

endmodule

// File: rtl/and_or_pipe.sv
// Pipelined per-lane f = x1 & x2, g = f | x3 with selectable AND source and a transfer counter.
module and_or_pipe
  import and_or_pipe_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic [WIDTH-1:0]   x1,
  input  logic [WIDTH-1:0]   x2,
  input  logic [WIDTH-1:0]   x3,
  input  logic               order,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   f,
  output logic [WIDTH-1:0]   g,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] xfer_cnt
);

  logic [WIDTH-1:0]   w_fa;
  logic [WIDTH-1:0]   w_ga;
  logic               w_accept;
  logic [DEPTH:0]     w_valid;
  logic [DEPTH:0]     w_ready;
  logic [2*WIDTH-1:0] w_data [DEPTH+1];

  logic [WIDTH-1:0]   r_fprev;
  logic [COUNT_W-1:0] r_cnt;

  // Evaluation at accept: the OR takes either this sample's AND or the last accepted one.
  always_comb begin
    w_fa = x1 & x2;
    w_ga = (order == ORDER_CURR) ? (w_fa | x3) : (r_fprev | x3);
  end

  assign in_ready   = w_ready[0] && Resetn;
  assign w_accept   = in_valid && in_ready;
  assign w_valid[0] = in_valid;
  assign w_data[0]  = {w_fa, w_ga};
  assign w_ready[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    and_or_pipe_stage #(.DATA_W(2*WIDTH)) u_stage (
      .i_clk      (Clock),
      .i_rst_n    (Resetn),
      .i_up_valid (w_valid[k]),
      .i_up_data  (w_data[k]),
      .o_up_ready (w_ready[k]),
      .o_dn_valid (w_valid[k+1]),
      .o_dn_data  (w_data[k+1]),
      .i_dn_ready (w_ready[k+1])
    );
  end

  assign out_valid = w_valid[DEPTH];
  assign f         = w_data[DEPTH][2*WIDTH-1:WIDTH];
  assign g         = w_data[DEPTH][WIDTH-1:0];
  assign xfer_cnt  = r_cnt;

  // f_prev only tracks accepted samples; idle and stalled cycles leave it alone.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_fprev <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) r_fprev <= w_fa;
      if (out_valid && out_ready) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: doc/and_or_pipe.md
Name: and_or_pipe

Overview:
- Parametrised, pipelined successor to the single-bit f/g register pair.
- Per bit lane: f = x1 & x2; g = f | x3.
- Per-sample evaluation order is selectable:
  - order=0: g uses the f of the previous accepted sample.
  - order=1: g uses the f of the current sample.
- Samples travel through a DEPTH-stage valid/ready pipeline with backpressure. A wrapping counter records completed output transfers. Sits between a streaming producer and consumer in the lab datapath.

Parameters:
- WIDTH, 8: lane count (bit width of x1/x2/x3/f/g).
- DEPTH, 2: pipeline stages, >=1; sets latency.
- COUNT_W, 16: width of xfer_cnt.

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous active-low reset.
- x1  in  WIDTH  operand A.
- x2  in  WIDTH  operand B.
- x3  in  WIDTH  OR operand.
- order  in  1  evaluation order; sampled with each accepted sample.
- in_valid  in  1  producer has a sample.
- in_ready  out  1  block accepts the sample this cycle.
- f  out  WIDTH  AND result of the output-stage sample.
- g  out  WIDTH  OR result of the output-stage sample.
- out_valid  out  1  f/g are valid.
- out_ready  in  1  consumer takes f/g this cycle.
- xfer_cnt  out  COUNT_W  completed output transfers, wrapping.

Behaviour:
Reset
- Resetn low clears immediately, without waiting for Clock: all stage valid bits, f, g, out_valid, f_prev, xfer_cnt → 0.
- in_ready forced 0 while Resetn is low.
- Reset mid-operation discards in-flight samples; none are emitted after release.
- First accept is possible on the first rising edge with Resetn high.

Acceptance
- A sample is accepted on an edge where in_valid & in_ready.
- Evaluation at accept:
  - fa = x1 & x2.
  - order=1: ga = fa | x3.
  - order=0: ga = f_prev | x3.
- After computing ga, f_prev <= fa.
- f_prev changes only on accept: stalls, bubbles and order changes between samples do not touch it.
- Stage 0 captures {fa, ga}.

Pipeline
- Stages 0..DEPTH-1; stage DEPTH-1 drives f/g/out_valid.
- Stage k advances when its valid is clear or stage k+1 advances. The last stage advances when out_valid & out_ready.
- in_ready = stage 0 can load, i.e. !valid[0] or stage 0 advances. This is a combinational path from out_ready and is allowed.
- Full throughput: one sample per cycle when out_ready stays high.
- Latency: a sample accepted on edge E is presented after edge E+DEPTH-1. For DEPTH=1 it is visible right after E.
- With out_ready low, stage contents hold exactly and f/g stay stable. At most DEPTH samples are buffered; in_ready then drops.
- Order is preserved; no sample is lost or duplicated.
- out_valid low: f/g hold their last values (not cleared).

Transfer counter
- xfer_cnt increments by 1 on every edge with out_valid & out_ready.
- Wraps from 2^COUNT_W-1 to 0.
- Simultaneous accept and output in the same edge are both performed.

Decomposition:
- Shared package: default WIDTH/DEPTH/COUNT_W constants, ORDER_PREV=0 and ORDER_CURR=1 constants.
- One sub-module, and_or_pipe_stage: single valid/ready register slice of width 2*WIDTH with async active-low clear, instantiated DEPTH times via generate.
- Evaluation logic, f_prev and the counter stay in the top.

Test Plan:
1. Reset: assert Resetn=0 mid-cycle with 2 samples in flight → out_valid, f, g, xfer_cnt read 0 before the next edge; in_ready=0. After release, no stale sample appears.
2. WIDTH=8, DEPTH=2, order=1, out_ready=1: x1=F0, x2=3C, x3=01 → f=30, g=31, out_valid=1 after the second edge; xfer_cnt=1 one edge later.
3. order=0 sequence after reset:
   - Sample 1: x1=FF, x2=0F, x3=00 → f=0F, g=00.
   - Sample 2: x1=00, x2=00, x3=F0 → f=00, g=FF.
4. Backpressure, DEPTH=2: out_ready=0 for 5 cycles with continuous in_valid → exactly 2 samples accepted, then in_ready=0 and f/g constant. Release out_ready → samples emerge in order, one per cycle, none lost.
5. Mixed order with stall: accept A (order=0), stall 3 cycles with in_valid=0, accept B (order=0) → B.g = A.f | B.x3. f_prev is unaffected by the idle cycles.
6. Counter wrap, COUNT_W=4: 17 output transfers → xfer_cnt=1.
